// File: rtl/piece_ctrl_pkg.sv
// piece_ctrl_pkg: shared game types, board geometry and tetromino shape table
package piece_ctrl_pkg;
   localparam int GAME_W = 10;
   localparam int GAME_H = 20;
   typedef enum logic [2:0] {PT_I, PT_O, PT_T, PT_S, PT_Z, PT_J, PT_L} piece_type_t;
   typedef enum logic [1:0] {MC_LEFT, MC_RIGHT, MC_DOWN, MC_ROT_CW} move_cmd_t;
   typedef enum logic [2:0] {ST_IDLE, ST_SPAWN_CHECK, ST_READY, ST_CHECK, ST_LOCK, ST_OVER} ctrl_state_t;
   typedef struct packed {
      logic [GAME_W-1:0][GAME_H-1:0] screen;
   } game_state_t;
   // Each rotation lists its four cells as {x[1:0], y[1:0]} nibbles; table words run rot3..rot0.
   function automatic logic [3:0][3:0] piece_shape(piece_type_t t, logic [1:0] rot);
      logic [3:0][15:0] tbl;
      logic [15:0] c;
      logic [3:0][3:0] m;
      case (t)
         PT_I:    tbl = {16'h4567, 16'h26AE, 16'h89AB, 16'h159D};
         PT_T:    tbl = {16'h4156, 16'h1596, 16'h4596, 16'h4159};
         PT_S:    tbl = {16'h0156, 16'h5926, 16'h459A, 16'h4815};
         PT_Z:    tbl = {16'h4152, 16'h156A, 16'h8596, 16'h0459};
         PT_J:    tbl = {16'h4526, 16'h159A, 16'h4856, 16'h0159};
         PT_L:    tbl = {16'h0456, 16'h1592, 16'h456A, 16'h8159};
         default: tbl = {4{16'h4589}};
      endcase
      c = tbl[rot];
      m = '0;
      for (int k = 0; k < 4; k++) m[c[4*k+2 +: 2]][c[4*k +: 2]] = 1'b1;
      return m;
   endfunction
endpackage

// File: rtl/piece_ctrl_collision_check.sv
// collision_check: tests a 4x4 piece mask, shifted by dx/dy, against the 6x6 neighbourhood window
module collision_check (
   input  logic [5:0][5:0]  window,
   input  logic [3:0][3:0]  mask,
   input  logic signed [1:0] dx,
   input  logic             dy,
   output logic             hit
);
   // Mask cell (i,j) lands on window cell (1+i+dx, 1+j+dy); any occupied overlap is a hit.
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            hit = hit | (mask[i][j] & window[3'(i + 1 + int'(dx))][3'(j + 1 + int'(dy))]);
   end
endmodule

// File: rtl/piece_ctrl.sv
// piece_ctrl: active-piece FSM accepting or rejecting moves against the sampled neighbourhood
module piece_ctrl import piece_ctrl_pkg::*; #(
   parameter int BOARD_WIDTH  = GAME_W,
   parameter int BOARD_HEIGHT = GAME_H,
   parameter int SPAWN_X      = 3
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            spawn,
   input  piece_type_t                     spawn_type,
   input  logic                            cmd_valid,
   input  move_cmd_t                       cmd,
   output logic                            cmd_ready,
   input  logic [5:0][5:0]                 window,
   output logic [$clog2(BOARD_WIDTH)-1:0]  piece_x,
   output logic [$clog2(BOARD_HEIGHT)-1:0] piece_y,
   output piece_type_t                     piece_type,
   output logic [1:0]                      piece_rot,
   output logic                            piece_active,
   output logic                            cmd_blocked,
   output logic                            lock_valid,
   output logic                            game_over
);
   localparam int XW = $clog2(BOARD_WIDTH);
   localparam int YW = $clog2(BOARD_HEIGHT);
   ctrl_state_t state_q, state_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [1:0] rot_q, rot_d;
   piece_type_t type_q, type_d;
   move_cmd_t cmd_q, cmd_d;
   logic in_check, hit, blocked;
   logic signed [1:0] dx;
   logic [3:0][3:0] mask;
   assign in_check = state_q == ST_CHECK;
   assign dx = !in_check ? 2'sd0 : cmd_q == MC_LEFT ? -2'sd1 : cmd_q == MC_RIGHT ? 2'sd1 : 2'sd0;
   assign mask = piece_shape(type_q, rot_q + 2'(in_check && cmd_q == MC_ROT_CW));
   collision_check u_cc (
      .window(window),
      .mask  (mask),
      .dx    (dx),
      .dy    (in_check && cmd_q == MC_DOWN),
      .hit   (hit)
   );
   // x is unsigned, so a left move from column 0 can never be legal
   assign blocked = hit || (cmd_q == MC_LEFT && x_q == '0);
   assign cmd_ready = state_q == ST_READY;
   assign piece_active = state_q == ST_READY || state_q == ST_CHECK || state_q == ST_LOCK;
   assign cmd_blocked = in_check && blocked && cmd_q != MC_DOWN;
   assign lock_valid = state_q == ST_LOCK;
   assign game_over = state_q == ST_OVER;
   assign piece_x = x_q;
   assign piece_y = y_q;
   assign piece_type = type_q;
   assign piece_rot = rot_q;
   // State and piece registers; reset drops any in-flight command
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q <= ST_IDLE;
         x_q <= '0;
         y_q <= '0;
         rot_q <= '0;
         type_q <= PT_I;
         cmd_q <= MC_LEFT;
      end else begin
         state_q <= state_d;
         x_q <= x_d;
         y_q <= y_d;
         rot_q <= rot_d;
         type_q <= type_d;
         cmd_q <= cmd_d;
      end
   // Next state: spawn, accept a command, then commit, reject or lock on the checked candidate
   always_comb begin
      state_d = state_q;
      x_d = x_q;
      y_d = y_q;
      rot_d = rot_q;
      type_d = type_q;
      cmd_d = cmd_q;
      case (state_q)
         ST_IDLE: if (spawn) begin
            x_d = XW'(SPAWN_X);
            y_d = '0;
            rot_d = '0;
            type_d = spawn_type;
            state_d = ST_SPAWN_CHECK;
         end
         ST_SPAWN_CHECK: state_d = hit ? ST_OVER : ST_READY;
         ST_READY: if (cmd_valid) begin
            cmd_d = cmd;
            state_d = ST_CHECK;
         end
         ST_CHECK: begin
            state_d = blocked && cmd_q == MC_DOWN ? ST_LOCK : ST_READY;
            if (!blocked) begin
               x_d = cmd_q == MC_LEFT ? x_q - 1'b1 : cmd_q == MC_RIGHT ? x_q + 1'b1 : x_q;
               y_d = cmd_q == MC_DOWN ? y_q + 1'b1 : y_q;
               rot_d = cmd_q == MC_ROT_CW ? rot_q + 2'd1 : rot_q;
            end
         end
         ST_LOCK: state_d = ST_IDLE;
         default: ;
      endcase
   end
endmodule

// File: tb/tb_piece_ctrl.sv
// tb_piece_ctrl: randomized and directed checks of piece_ctrl against a geometric board model
module tb_piece_ctrl;
   import piece_ctrl_pkg::*;
   logic clk = 0, reset_n = 1, spawn = 0, cmd_valid = 0;
   piece_type_t spawn_type = PT_I;
   move_cmd_t cmd = MC_LEFT;
   logic cmd_ready, piece_active, cmd_blocked, lock_valid, game_over;
   logic [5:0][5:0] window;
   logic [3:0] piece_x;
   logic [4:0] piece_y;
   piece_type_t piece_type;
   logic [1:0] piece_rot;
   logic [9:0][19:0] scr = '0;
   int n_cmp = 0, n_bad = 0;
   int m_x = 0, m_y = 0, m_r = 0, m_t = 0;
   // Rotation-0 shapes as bitmaps, bit y*4+x; other rotations are produced by turning the box.
   localparam logic [15:0] ROT0 [7] = '{16'h00F0, 16'h0066, 16'h0072, 16'h0036, 16'h0063, 16'h0071, 16'h0074};

   piece_ctrl dut (
      .clk(clk), .reset_n(reset_n), .spawn(spawn), .spawn_type(spawn_type),
      .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready), .window(window),
      .piece_x(piece_x), .piece_y(piece_y), .piece_type(piece_type), .piece_rot(piece_rot),
      .piece_active(piece_active), .cmd_blocked(cmd_blocked), .lock_valid(lock_valid),
      .game_over(game_over)
   );

   always #5 clk = ~clk;

   function automatic logic board_at(logic [9:0][19:0] b, int cx, int cy);
      return (cx < 0 || cx > 9 || cy < 0 || cy > 19) ? 1'b1 : b[4'(cx)][5'(cy)];
   endfunction

   always_comb
      for (int lx = 0; lx < 6; lx++)
         for (int ly = 0; ly < 6; ly++)
            window[3'(lx)][3'(ly)] = board_at(scr, int'(piece_x) + lx - 1, int'(piece_y) + ly - 1);

   // Cell (x,y) of the box belongs to the piece if turning it back r quarter-turns lands on a rot-0 cell.
   function automatic bit in_shape(int t, int r, int x, int y);
      int n, tx;
      n = (t <= 1) ? 4 : 3;
      if (t == 1) r = 0;
      for (int k = 0; k < r; k++) begin
         tx = x;
         x = y;
         y = n - 1 - tx;
      end
      if (x < 0 || y < 0 || x >= n || y >= n) return 0;
      return ROT0[3'(t)][4'(y * 4 + x)];
   endfunction

   function automatic bit fits(int t, int r, int x, int y);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            if (in_shape(t, r, i, j) && board_at(scr, x + i, y + j)) return 0;
      return 1;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut;
      reset_n = 0; spawn = 0; cmd_valid = 0; scr = '0;
      #2;
      tick;
      reset_n = 1;
      m_x = 0; m_y = 0; m_r = 0; m_t = 0;
   endtask

   task automatic spawn_piece(input int t, output bit over);
      spawn = 1; spawn_type = piece_type_t'(3'(t));
      tick;
      spawn = 0;
      n_cmp++; if ({cmd_ready, piece_active} !== 2'b00) begin n_bad++; $display("FAIL spawn_check_phase got=%b want=00", {cmd_ready, piece_active}); end
      tick;
      m_t = t; m_x = 3; m_y = 0; m_r = 0;
      over = !fits(t, 0, 3, 0);
      if (over) begin
         n_cmp++; if ({game_over, piece_active, cmd_ready} !== 3'b100) begin n_bad++; $display("FAIL spawn_over got=%b want=100", {game_over, piece_active, cmd_ready}); end
      end else begin
         n_cmp++; if ({game_over, piece_active, cmd_ready} !== 3'b011) begin n_bad++; $display("FAIL spawn_ready got=%b want=011", {game_over, piece_active, cmd_ready}); end
         n_cmp++; if ({piece_x, piece_y, piece_rot, piece_type} !== {4'd3, 5'd0, 2'd0, 3'(t)}) begin n_bad++; $display("FAIL spawn_pos got=%h want=%h", {piece_x, piece_y, piece_rot, piece_type}, {4'd3, 5'd0, 2'd0, 3'(t)}); end
      end
   endtask

   task automatic apply_cmd(input move_cmd_t c, input bit junk, output bit locked);
      int nx, ny, nr;
      bit ok;
      locked = 0;
      n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL ready_before_cmd got=%b want=1", cmd_ready); end
      cmd_valid = 1; cmd = c;
      tick;
      nx = m_x; ny = m_y; nr = m_r;
      case (c)
         MC_LEFT:  nx--;
         MC_RIGHT: nx++;
         MC_DOWN:  ny++;
         default:  nr = (nr + 1) % 4;
      endcase
      ok = fits(m_t, nr, nx, ny) && !(c == MC_LEFT && m_x == 0);
      if (junk) cmd = move_cmd_t'(2'($urandom_range(0, 3)));
      else cmd_valid = 0;
      n_cmp++; if (cmd_blocked !== (!ok && c != MC_DOWN)) begin n_bad++; $display("FAIL cmd_blocked cmd=%0d got=%b want=%b", c, cmd_blocked, !ok && c != MC_DOWN); end
      n_cmp++; if ({cmd_ready, lock_valid, piece_active} !== 3'b001) begin n_bad++; $display("FAIL check_phase got=%b want=001", {cmd_ready, lock_valid, piece_active}); end
      tick;
      cmd_valid = 0;
      if (ok) begin
         m_x = nx; m_y = ny; m_r = nr;
      end
      n_cmp++; if ({piece_x, piece_y, piece_rot} !== {4'(m_x), 5'(m_y), 2'(m_r)}) begin n_bad++; $display("FAIL cmd_pos cmd=%0d got=%h want=%h", c, {piece_x, piece_y, piece_rot}, {4'(m_x), 5'(m_y), 2'(m_r)}); end
      if (!ok && c == MC_DOWN) begin
         n_cmp++; if ({lock_valid, cmd_ready, cmd_blocked} !== 3'b100) begin n_bad++; $display("FAIL lock_pulse got=%b want=100", {lock_valid, cmd_ready, cmd_blocked}); end
         tick;
         n_cmp++; if ({lock_valid, piece_active, cmd_ready} !== 3'b000) begin n_bad++; $display("FAIL after_lock got=%b want=000", {lock_valid, piece_active, cmd_ready}); end
         locked = 1;
      end else begin
         n_cmp++; if ({cmd_ready, cmd_blocked, lock_valid} !== 3'b100) begin n_bad++; $display("FAIL back_to_ready got=%b want=100", {cmd_ready, cmd_blocked, lock_valid}); end
         if (junk) begin
            tick;
            n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL not_queued got=%b want=1", cmd_ready); end
         end
      end
   endtask

   task automatic test_reset;
      reset_n = 0; spawn = 0; cmd_valid = 0;
      #2;
      n_cmp++; if ({piece_x, piece_y, piece_type, piece_rot} !== 14'd0) begin n_bad++; $display("FAIL reset_pos got=%h want=0", {piece_x, piece_y, piece_type, piece_rot}); end
      n_cmp++; if ({piece_active, cmd_ready, cmd_blocked, lock_valid, game_over} !== 5'd0) begin n_bad++; $display("FAIL reset_flags got=%b want=00000", {piece_active, cmd_ready, cmd_blocked, lock_valid, game_over}); end
      tick;
      reset_n = 1;
      tick;
      tick;
      n_cmp++; if ({piece_active, cmd_ready, game_over} !== 3'd0) begin n_bad++; $display("FAIL idle_after_reset got=%b want=000", {piece_active, cmd_ready, game_over}); end
   endtask

   task automatic test_right;
      bit ov, lk;
      reset_dut;
      spawn_piece(1, ov);
      for (int k = 0; k < 5; k++) begin
         apply_cmd(MC_RIGHT, 0, lk);
         n_cmp++; if (piece_x !== 4'(k < 4 ? 4 + k : 7)) begin n_bad++; $display("FAIL right_x step=%0d got=%0d want=%0d", k, piece_x, k < 4 ? 4 + k : 7); end
      end
   endtask

   task automatic test_drop;
      bit ov, lk;
      int steps;
      reset_dut;
      spawn_piece(1, ov);
      lk = 0; steps = 0;
      while (!lk && steps < 25) begin
         apply_cmd(MC_DOWN, 0, lk);
         steps++;
      end
      n_cmp++; if (!lk || steps != 19) begin n_bad++; $display("FAIL drop_steps got=%0d want=19", steps); end
      n_cmp++; if ({piece_x, piece_y} !== {4'd3, 5'd18}) begin n_bad++; $display("FAIL drop_final got=%0d,%0d want=3,18", piece_x, piece_y); end
   endtask

   task automatic test_game_over;
      bit ov;
      reset_dut;
      scr[4][0] = 1'b1;
      spawn_piece(1, ov);
      spawn = 1; cmd_valid = 1;
      repeat (3) tick;
      spawn = 0; cmd_valid = 0;
      n_cmp++; if ({game_over, piece_active, cmd_ready} !== 3'b100) begin n_bad++; $display("FAIL over_sticky got=%b want=100", {game_over, piece_active, cmd_ready}); end
      reset_n = 0;
      #1;
      n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL over_cleared got=%b want=0", game_over); end
      tick;
      reset_n = 1;
   endtask

   task automatic test_rotate;
      bit ov, lk;
      reset_dut;
      spawn_piece(0, ov);
      scr[5][3] = 1'b1;
      apply_cmd(MC_ROT_CW, 0, lk);
      n_cmp++; if (piece_rot !== 2'd0) begin n_bad++; $display("FAIL rot_blocked got=%0d want=0", piece_rot); end
      scr[5][3] = 1'b0;
      apply_cmd(MC_ROT_CW, 0, lk);
      n_cmp++; if (piece_rot !== 2'd1) begin n_bad++; $display("FAIL rot_free got=%0d want=1", piece_rot); end
   endtask

   task automatic test_reset_in_check;
      bit ov;
      reset_dut;
      spawn_piece(1, ov);
      cmd_valid = 1; cmd = MC_RIGHT;
      tick;
      cmd_valid = 0;
      #1;
      reset_n = 0;
      #1;
      n_cmp++; if ({piece_x, piece_active, cmd_ready, cmd_blocked} !== 7'd0) begin n_bad++; $display("FAIL async_reset got=%h want=0", {piece_x, piece_active, cmd_ready, cmd_blocked}); end
      tick;
      reset_n = 1;
      tick;
      n_cmp++; if ({piece_x, piece_y, piece_active, cmd_ready} !== 11'd0) begin n_bad++; $display("FAIL after_release got=%h want=0", {piece_x, piece_y, piece_active, cmd_ready}); end
   endtask

   task automatic test_random;
      bit ov, lk;
      int r;
      move_cmd_t c;
      for (int run = 0; run < 15; run++) begin
         reset_dut;
         for (int x = 0; x < 10; x++)
            for (int y = 8; y < 20; y++)
               scr[x][y] = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 5) == 0) scr[4'($urandom_range(0, 9))][5'($urandom_range(0, 2))] = 1'b1;
         spawn_piece(int'($urandom_range(0, 6)), ov);
         lk = 0;
         for (int k = 0; k < 40 && !ov && !lk; k++) begin
            r = int'($urandom_range(0, 9));
            c = r < 2 ? MC_LEFT : r < 4 ? MC_RIGHT : r < 7 ? MC_DOWN : MC_ROT_CW;
            apply_cmd(c, $urandom_range(0, 3) == 0, lk);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset;
      test_right;
      test_drop;
      test_game_over;
      test_rotate;
      test_reset_in_check;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
